axi_rd_arbiter: RTL and testbench

- Shares one bus-side AXI read master port (address + read-data channels) between N local read requesters, e.g. a DMA engine and a control master.
- Sits between the requesters and the bus port that feeds the bus/master clock-domain crossing.
- Arbitrates read-address requests and tags each request with the requester index as the bus ID.
- Limits outstanding bursts per requester and routes returning read data by ID.

---
 rtl/axi_rd_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one bus-side AXI read master port between N local
// read requesters.
//
// Address path: a two-state FSM (IDLE/OFFER) picks one eligible requester,
// captures its address fields into a registered bus-side offer tagged with
// the requester index as the bus ID, and holds the offer until the bus
// accepts it. Read data returning from the bus is steered back to the
// requester named by its ID with zero latency.
//
// Optional build macro:
//   ARB_FIXED_PRIO_EN  lowest-index eligible requester always wins (no
//                      fairness). Undefined: round-robin from a pointer that
//                      advances past the last accepted requester.
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   M_RD_ADDR/_LEN/_BURST         per-requester address fields, slice i = requester i
//   M_RD_ADDR_VALID/_READY        per-requester address handshake (READY is combinational)
//   M_RD_DATA/_RESP/_LAST         shared read-data fields, zero when no requester is addressed
//   M_RD_DATA_VALID/_READY        per-requester read-data handshake
//   B_RD_ADDR_ID/ADDR/LEN/BURST   registered bus address fields
//   B_RD_ADDR_VALID/_READY        bus address handshake
//   B_RD_BACK_ID, B_RD_DATA/_RESP/_LAST, B_RD_DATA_VALID/_READY  bus read-data channel
//   id_err                        sticky: a read beat arrived with an invalid ID
module axi_rd_arbiter #(
    parameter int unsigned N          = 2,
    parameter int unsigned MAX_OUTSTD = 4
) (
    input  logic            CLK,
    input  logic            RST,

    input  logic [N*32-1:0] M_RD_ADDR,
    input  logic [N*8-1:0]  M_RD_ADDR_LEN,
    input  logic [N*2-1:0]  M_RD_ADDR_BURST,
    input  logic [N-1:0]    M_RD_ADDR_VALID,
    output logic [N-1:0]    M_RD_ADDR_READY,

    output logic [31:0]     M_RD_DATA,
    output logic [1:0]      M_RD_DATA_RESP,
    output logic            M_RD_DATA_LAST,
    output logic [N-1:0]    M_RD_DATA_VALID,
    input  logic [N-1:0]    M_RD_DATA_READY,

    output logic [1:0]      B_RD_ADDR_ID,
    output logic [31:0]     B_RD_ADDR,
    output logic [7:0]      B_RD_ADDR_LEN,
    output logic [1:0]      B_RD_ADDR_BURST,
    output logic            B_RD_ADDR_VALID,
    input  logic            B_RD_ADDR_READY,

    input  logic [1:0]      B_RD_BACK_ID,
    input  logic [31:0]     B_RD_DATA,
    input  logic [1:0]      B_RD_DATA_RESP,
    input  logic            B_RD_DATA_LAST,
    input  logic            B_RD_DATA_VALID,
    output logic            B_RD_DATA_READY,

    output logic            id_err
);

    localparam int unsigned AW    = 32;
    localparam int unsigned LW    = 8;
    localparam int unsigned BW    = 2;
    localparam int unsigned IDW   = 2;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTD);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_nxt;

    logic [CNT_W-1:0] cnt_q [N];
    logic [N-1:0]     elig;
    logic [N-1:0]     cnt_inc;
    logic [N-1:0]     cnt_dec;

    logic             win_vld;
    logic [IDW-1:0]   win_idx;
    logic [AW-1:0]    sel_addr;
    logic [LW-1:0]    sel_len;
    logic [BW-1:0]    sel_burst;

    logic             id_ok;
    logic             data_on;

`ifndef ARB_FIXED_PRIO_EN
    logic [IDW-1:0]   rr_ptr_q;
`endif

    // Address FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Address FSM next state, winner selection and requester READY
    always_comb begin
        state_nxt       = state_q;
        elig            = '0;
        win_vld         = 1'b0;
        win_idx         = '0;
        M_RD_ADDR_READY = '0;
        cnt_inc         = '0;
        sel_addr        = '0;
        sel_len         = '0;
        sel_burst       = '0;

        for (int i = 0; i < int'(N); i++) begin
            elig[i] = M_RD_ADDR_VALID[i] && (cnt_q[i] < CNT_MAX);
        end

        case (state_q)
            S_IDLE: begin
                if (!RST) begin
`ifdef ARB_FIXED_PRIO_EN
                    // Descending scan so the lowest eligible index is kept
                    for (int i = int'(N) - 1; i >= 0; i--) begin
                        if (elig[i]) begin
                            win_vld = 1'b1;
                            win_idx = IDW'(i);
                        end
                    end
`else
                    // Descending distance from the pointer so the nearest
                    // eligible requester (in rotation order) is kept
                    for (int k = int'(N) - 1; k >= 0; k--) begin
                        for (int i = 0; i < int'(N); i++) begin
                            if ((i == (int'(rr_ptr_q) + k) % int'(N)) && elig[i]) begin
                                win_vld = 1'b1;
                                win_idx = IDW'(i);
                            end
                        end
                    end
`endif
                end
                if (win_vld) begin
                    state_nxt = S_OFFER;
                end
            end
            S_OFFER: begin
                if (B_RD_ADDR_READY) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        for (int i = 0; i < int'(N); i++) begin
            if (win_vld && (win_idx == IDW'(i))) begin
                M_RD_ADDR_READY[i] = 1'b1;
                cnt_inc[i]         = 1'b1;
                sel_addr           = M_RD_ADDR[i*AW +: AW];
                sel_len            = M_RD_ADDR_LEN[i*LW +: LW];
                sel_burst          = M_RD_ADDR_BURST[i*BW +: BW];
            end
        end
    end

    // Read-data routing by returned ID; beats for an unknown or idle ID are drained
    always_comb begin
        id_ok           = 1'b0;
        M_RD_DATA_VALID = '0;
        B_RD_DATA_READY = 1'b1;
        cnt_dec         = '0;

        for (int i = 0; i < int'(N); i++) begin
            if ((B_RD_BACK_ID == IDW'(i)) && (cnt_q[i] != '0)) begin
                id_ok              = 1'b1;
                M_RD_DATA_VALID[i] = B_RD_DATA_VALID;
                B_RD_DATA_READY    = M_RD_DATA_READY[i];
                cnt_dec[i]         = B_RD_DATA_VALID && M_RD_DATA_READY[i] && B_RD_DATA_LAST;
            end
        end

        data_on        = |M_RD_DATA_VALID;
        M_RD_DATA      = data_on ? B_RD_DATA      : '0;
        M_RD_DATA_RESP = data_on ? B_RD_DATA_RESP : '0;
        M_RD_DATA_LAST = data_on && B_RD_DATA_LAST;
    end

    // Bus offer register, rotation pointer and sticky ID error
    always_ff @(posedge CLK) begin
        if (RST) begin
            B_RD_ADDR_ID    <= '0;
            B_RD_ADDR       <= '0;
            B_RD_ADDR_LEN   <= '0;
            B_RD_ADDR_BURST <= '0;
            B_RD_ADDR_VALID <= 1'b0;
            id_err          <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q        <= '0;
`endif
        end else begin
            if (win_vld) begin
                B_RD_ADDR_ID    <= win_idx;
                B_RD_ADDR       <= sel_addr;
                B_RD_ADDR_LEN   <= sel_len;
                B_RD_ADDR_BURST <= sel_burst;
                B_RD_ADDR_VALID <= 1'b1;
            end else if ((state_q == S_OFFER) && B_RD_ADDR_READY) begin
                B_RD_ADDR_VALID <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
                rr_ptr_q        <= IDW'((int'(B_RD_ADDR_ID) + 1) % int'(N));
`endif
            end
            if (B_RD_DATA_VALID && !id_ok) begin
                id_err <= 1'b1;
            end
        end
    end

    // Outstanding-burst counters; a simultaneous grant and LAST beat cancel out
    always_ff @(posedge CLK) begin
        for (int i = 0; i < int'(N); i++) begin
            if (RST) begin
                cnt_q[i] <= '0;
            end else if (cnt_inc[i] && !cnt_dec[i]) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end else if (cnt_dec[i] && !cnt_inc[i]) begin
                cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

    localparam int unsigned N          = 2;
    localparam int unsigned MAX_OUTSTD = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N*32-1:0] M_RD_ADDR;
    logic [N*8-1:0]  M_RD_ADDR_LEN;
    logic [N*2-1:0]  M_RD_ADDR_BURST;
    logic [N-1:0]    M_RD_ADDR_VALID;
    logic [N-1:0]    M_RD_ADDR_READY;
    logic [31:0]     M_RD_DATA;
    logic [1:0]      M_RD_DATA_RESP;
    logic            M_RD_DATA_LAST;
    logic [N-1:0]    M_RD_DATA_VALID;
    logic [N-1:0]    M_RD_DATA_READY;
    logic [1:0]      B_RD_ADDR_ID;
    logic [31:0]     B_RD_ADDR;
    logic [7:0]      B_RD_ADDR_LEN;
    logic [1:0]      B_RD_ADDR_BURST;
    logic            B_RD_ADDR_VALID;
    logic            B_RD_ADDR_READY;
    logic [1:0]      B_RD_BACK_ID;
    logic [31:0]     B_RD_DATA;
    logic [1:0]      B_RD_DATA_RESP;
    logic            B_RD_DATA_LAST;
    logic            B_RD_DATA_VALID;
    logic            B_RD_DATA_READY;
    logic            id_err;

    axi_rd_arbiter #(.N(N), .MAX_OUTSTD(MAX_OUTSTD)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .M_RD_ADDR       (M_RD_ADDR),
        .M_RD_ADDR_LEN   (M_RD_ADDR_LEN),
        .M_RD_ADDR_BURST (M_RD_ADDR_BURST),
        .M_RD_ADDR_VALID (M_RD_ADDR_VALID),
        .M_RD_ADDR_READY (M_RD_ADDR_READY),
        .M_RD_DATA       (M_RD_DATA),
        .M_RD_DATA_RESP  (M_RD_DATA_RESP),
        .M_RD_DATA_LAST  (M_RD_DATA_LAST),
        .M_RD_DATA_VALID (M_RD_DATA_VALID),
        .M_RD_DATA_READY (M_RD_DATA_READY),
        .B_RD_ADDR_ID    (B_RD_ADDR_ID),
        .B_RD_ADDR       (B_RD_ADDR),
        .B_RD_ADDR_LEN   (B_RD_ADDR_LEN),
        .B_RD_ADDR_BURST (B_RD_ADDR_BURST),
        .B_RD_ADDR_VALID (B_RD_ADDR_VALID),
        .B_RD_ADDR_READY (B_RD_ADDR_READY),
        .B_RD_BACK_ID    (B_RD_BACK_ID),
        .B_RD_DATA       (B_RD_DATA),
        .B_RD_DATA_RESP  (B_RD_DATA_RESP),
        .B_RD_DATA_LAST  (B_RD_DATA_LAST),
        .B_RD_DATA_VALID (B_RD_DATA_VALID),
        .B_RD_DATA_READY (B_RD_DATA_READY),
        .id_err          (id_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
    } grant_t;

    // Read-data routing vector: inputs then expected outputs
    typedef struct {
        logic [1:0] id;
        logic       vld;
        logic       last;
        logic [1:0] mrdy;
        logic [1:0] exp_mv;
        logic       exp_br;
        logic       exp_err;
    } vec_t;

    grant_t      exp_q[$];
    vec_t        vt[15];
    int          checks   = 0;
    int          failures = 0;

    // Outputs sampled mid-cycle by cycle()
    logic [N-1:0] s_ar_ready;
    logic         s_bvalid;
    logic [1:0]   s_bid;
    logic [31:0]  s_baddr;
    logic [7:0]   s_blen;
    logic [1:0]   s_bburst;
    logic [N-1:0] s_mvalid;
    logic         s_bready;
    logic [31:0]  s_mdata;
    logic [1:0]   s_mresp;
    logic         s_mlast;
    logic         s_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_grant(input logic [1:0] id, input logic [31:0] a,
                              input logic [7:0] l, input logic [1:0] b);
        grant_t g;
        g.id = id; g.addr = a; g.len = l; g.burst = b;
        exp_q.push_back(g);
    endtask

    // One clock: sample at the falling edge, score any bus address handshake,
    // then return just after the rising edge so the caller can drive inputs.
    task automatic cycle();
        grant_t g;
        @(negedge CLK);
        s_ar_ready = M_RD_ADDR_READY;
        s_bvalid   = B_RD_ADDR_VALID;
        s_bid      = B_RD_ADDR_ID;
        s_baddr    = B_RD_ADDR;
        s_blen     = B_RD_ADDR_LEN;
        s_bburst   = B_RD_ADDR_BURST;
        s_mvalid   = M_RD_DATA_VALID;
        s_bready   = B_RD_DATA_READY;
        s_mdata    = M_RD_DATA;
        s_mresp    = M_RD_DATA_RESP;
        s_mlast    = M_RD_DATA_LAST;
        s_err      = id_err;
        if (B_RD_ADDR_VALID && B_RD_ADDR_READY) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual id=%0d addr=0x%0h expected none", B_RD_ADDR_ID, B_RD_ADDR);
            end else begin
                g = exp_q.pop_front();
                check("sb_id",    64'(B_RD_ADDR_ID),    64'(g.id));
                check("sb_addr",  64'(B_RD_ADDR),       64'(g.addr));
                check("sb_len",   64'(B_RD_ADDR_LEN),   64'(g.len));
                check("sb_burst", 64'(B_RD_ADDR_BURST), 64'(g.burst));
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l,
                           input logic [1:0] b, input logic v);
        M_RD_ADDR[i*32 +: 32]     = a;
        M_RD_ADDR_LEN[i*8 +: 8]   = l;
        M_RD_ADDR_BURST[i*2 +: 2] = b;
        M_RD_ADDR_VALID[i]        = v;
    endtask

    task automatic set_beat(input logic [1:0] id, input logic v, input logic last,
                            input logic [1:0] mrdy, input logic [31:0] d, input logic [1:0] r);
        B_RD_BACK_ID    = id;
        B_RD_DATA_VALID = v;
        B_RD_DATA_LAST  = last;
        M_RD_DATA_READY = mrdy;
        B_RD_DATA       = d;
        B_RD_DATA_RESP  = r;
    endtask

    task automatic do_reset();
        RST             = 1'b1;
        M_RD_ADDR_VALID = '0;
        set_beat(2'd0, 1'b0, 1'b0, 2'b00, 32'h0, 2'd0);
        cycle();
        cycle();
        RST = 1'b0;
    endtask

    int          exp_order[6];
    logic [N-1:0] oh;

    initial begin
        RST             = 1'b1;
        M_RD_ADDR       = '0;
        M_RD_ADDR_LEN   = '0;
        M_RD_ADDR_BURST = '0;
        M_RD_ADDR_VALID = '0;
        B_RD_ADDR_READY = 1'b0;
        set_beat(2'd0, 1'b0, 1'b0, 2'b00, 32'h0, 2'd0);

        // Reset state, and no requester readied while reset is asserted
        cycle();
        set_req(0, 32'h0000_0100, 8'd1, 2'd1, 1'b1);
        cycle();
        check("rst_ar_ready", 64'(s_ar_ready), 64'(0));
        check("rst_bvalid",   64'(s_bvalid),   64'(0));
        check("rst_bid",      64'(s_bid),      64'(0));
        check("rst_baddr",    64'(s_baddr),    64'(0));
        check("rst_blen",     64'(s_blen),     64'(0));
        check("rst_bburst",   64'(s_bburst),   64'(0));
        check("rst_err",      64'(s_err),      64'(0));
        M_RD_ADDR_VALID = '0;
        RST = 1'b0;

        // Single request: offer appears one cycle after the requester handshake
        B_RD_ADDR_READY = 1'b1;
        set_req(0, 32'h0000_1000, 8'd3, 2'd1, 1'b1);
        push_grant(2'd0, 32'h0000_1000, 8'd3, 2'd1);
        cycle();
        check("single_ar_ready", 64'(s_ar_ready), 64'(2'b01));
        check("single_bvalid0",  64'(s_bvalid),   64'(0));
        M_RD_ADDR_VALID = '0;
        cycle();
        check("single_bvalid1",  64'(s_bvalid),   64'(1));
        check("single_bid",      64'(s_bid),      64'(0));
        check("single_baddr",    64'(s_baddr),    64'(32'h1000));
        check("single_blen",     64'(s_blen),     64'(3));
        check("single_ar_idle",  64'(s_ar_ready), 64'(0));
        // cnt[0]=1: one LAST beat is routed, the next one is not
        set_beat(2'd0, 1'b1, 1'b1, 2'b01, 32'hDEAD_0001, 2'd0);
        cycle();
        check("single_bvalid2",  64'(s_bvalid),   64'(0));
        check("single_route",    64'(s_mvalid),   64'(2'b01));
        cycle();
        check("single_cnt0",     64'(s_mvalid),   64'(0));
        check("single_drop_rdy", 64'(s_bready),   64'(1));
        set_beat(2'd0, 1'b0, 1'b0, 2'b00, 32'h0, 2'd0);
        cycle();
        check("single_err",      64'(s_err),      64'(1));

        // Contention: both requesters valid, bus always ready
        do_reset();
`ifdef ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        B_RD_ADDR_READY = 1'b1;
        set_req(0, 32'h0000_2000, 8'd1, 2'd1, 1'b1);
        set_req(1, 32'h0000_2100, 8'd2, 2'd1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (exp_order[k] == 0) push_grant(2'd0, 32'h0000_2000, 8'd1, 2'd1);
            else                   push_grant(2'd1, 32'h0000_2100, 8'd2, 2'd1);
            oh = '0;
            oh[exp_order[k]] = 1'b1;
            cycle();
            check($sformatf("cont_grant%0d", k), 64'(s_ar_ready), 64'(oh));
            cycle();
            check($sformatf("cont_offer%0d", k), 64'(s_ar_ready), 64'(0));
        end
        M_RD_ADDR_VALID = '0;

        // Outstanding limit: four grants to M0 without data, then blocked
        do_reset();
        B_RD_ADDR_READY = 1'b1;
        set_req(0, 32'h0000_5000, 8'd5, 2'd1, 1'b1);
        for (int c = 0; c < 12; c++) begin
            if ((c % 2 == 0) && (c < 8)) push_grant(2'd0, 32'h0000_5000, 8'd5, 2'd1);
            cycle();
            check($sformatf("lim_c%0d", c), 64'(s_ar_ready),
                  64'(((c % 2 == 0) && (c < 8)) ? 2'b01 : 2'b00));
        end
        set_beat(2'd0, 1'b1, 1'b1, 2'b01, 32'hBEEF_0000, 2'd0);
        cycle();
        check("lim_beat_ar", 64'(s_ar_ready), 64'(0));
        check("lim_beat_mv", 64'(s_mvalid),   64'(2'b01));
        set_beat(2'd0, 1'b0, 1'b0, 2'b00, 32'h0, 2'd0);
        push_grant(2'd0, 32'h0000_5000, 8'd5, 2'd1);
        cycle();
        check("lim_regrant", 64'(s_ar_ready), 64'(2'b01));
        M_RD_ADDR_VALID = '0;
        cycle();

        // Two M1 bursts outstanding for the routing table
        set_req(1, 32'h0000_6000, 8'd0, 2'd1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            push_grant(2'd1, 32'h0000_6000, 8'd0, 2'd1);
            cycle();
            check($sformatf("rt_setup%0d", k), 64'(s_ar_ready), 64'(2'b10));
            cycle();
        end
        M_RD_ADDR_VALID = '0;

        // Routing: cnt[0]=4, cnt[1]=2 going in
        vt[0]  = '{2'd1, 1'b1, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0};
        vt[1]  = '{2'd1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0};
        vt[2]  = '{2'd1, 1'b1, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0};
        vt[3]  = '{2'd1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0};
        vt[4]  = '{2'd1, 1'b1, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0};
        vt[5]  = '{2'd1, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0};
        vt[6]  = '{2'd1, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0};
        vt[7]  = '{2'd1, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0};
        vt[8]  = '{2'd0, 1'b1, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0};
        vt[9]  = '{2'd0, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0};
        vt[10] = '{2'd2, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
        vt[11] = '{2'd3, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
        vt[12] = '{2'd1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
        vt[13] = '{2'd1, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1};
        vt[14] = '{2'd1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
        for (int k = 0; k < 15; k++) begin
            set_beat(vt[k].id, vt[k].vld, vt[k].last, vt[k].mrdy,
                     32'hA000_0000 + 32'(k), 2'(k));
            cycle();
            check($sformatf("rt%0d_mvalid", k), 64'(s_mvalid), 64'(vt[k].exp_mv));
            check($sformatf("rt%0d_bready", k), 64'(s_bready), 64'(vt[k].exp_br));
            check($sformatf("rt%0d_data", k),   64'(s_mdata),
                  64'((vt[k].exp_mv != 2'b00) ? (32'hA000_0000 + 32'(k)) : 32'h0));
            check($sformatf("rt%0d_resp", k),   64'(s_mresp),
                  64'((vt[k].exp_mv != 2'b00) ? 2'(k) : 2'd0));
            check($sformatf("rt%0d_last", k),   64'(s_mlast),
                  64'((vt[k].exp_mv != 2'b00) && vt[k].last));
            check($sformatf("rt%0d_err", k),    64'(s_err),    64'(vt[k].exp_err));
        end
        set_beat(2'd0, 1'b0, 1'b0, 2'b00, 32'h0, 2'd0);

        // Held bus: offer stays stable while the bus stalls
        B_RD_ADDR_READY = 1'b0;
        set_req(0, 32'h0000_7000, 8'd1, 2'd1, 1'b1);
        set_req(1, 32'h0000_3000, 8'd7, 2'd2, 1'b1);
        push_grant(2'd1, 32'h0000_3000, 8'd7, 2'd2);
        cycle();
        check("hold_grant", 64'(s_ar_ready), 64'(2'b10));
        set_req(1, 32'h0000_4000, 8'd9, 2'd1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            cycle();
            check($sformatf("hold%0d_bvalid", c), 64'(s_bvalid),   64'(1));
            check($sformatf("hold%0d_bid", c),    64'(s_bid),      64'(1));
            check($sformatf("hold%0d_baddr", c),  64'(s_baddr),    64'(32'h3000));
            check($sformatf("hold%0d_blen", c),   64'(s_blen),     64'(7));
            check($sformatf("hold%0d_bburst", c), 64'(s_bburst),   64'(2));
            check($sformatf("hold%0d_ar", c),     64'(s_ar_ready), 64'(0));
        end
        B_RD_ADDR_READY = 1'b1;
        cycle();
        check("hold_release_ar", 64'(s_ar_ready), 64'(0));
        // Grant and LAST beat for M1 in the same cycle: cnt[1] stays at 1
        push_grant(2'd1, 32'h0000_4000, 8'd9, 2'd1);
        set_beat(2'd1, 1'b1, 1'b1, 2'b10, 32'hC000_0001, 2'd0);
        cycle();
        check("simul_grant", 64'(s_ar_ready), 64'(2'b10));
        check("simul_mv",    64'(s_mvalid),   64'(2'b10));
        M_RD_ADDR_VALID = '0;
        cycle();
        check("simul_cnt1_live", 64'(s_mvalid), 64'(2'b10));
        cycle();
        check("simul_cnt1_zero", 64'(s_mvalid), 64'(0));
        check("simul_drop_rdy",  64'(s_bready), 64'(1));
        set_beat(2'd0, 1'b0, 1'b0, 2'b00, 32'h0, 2'd0);
        check("err_sticky", 64'(s_err), 64'(1));

        // Reset while an offer is pending on a stalled bus
        B_RD_ADDR_READY = 1'b0;
        set_req(1, 32'h0000_8000, 8'd3, 2'd1, 1'b1);
        cycle();
        check("mid_grant", 64'(s_ar_ready), 64'(2'b10));
        cycle();
        check("mid_offer", 64'(s_bvalid), 64'(1));
        RST = 1'b1;
        cycle();
        check("mid_rst_ar", 64'(s_ar_ready), 64'(0));
        cycle();
        check("mid_rst_bvalid", 64'(s_bvalid), 64'(0));
        check("mid_rst_baddr",  64'(s_baddr),  64'(0));
        check("mid_rst_err",    64'(s_err),    64'(0));
        check("mid_rst_ar2",    64'(s_ar_ready), 64'(0));
        RST = 1'b0;
        M_RD_ADDR_VALID = '0;
        B_RD_ADDR_READY = 1'b1;
        set_req(0, 32'h0000_9000, 8'd2, 2'd3, 1'b1);
        push_grant(2'd0, 32'h0000_9000, 8'd2, 2'd3);
        cycle();
        check("post_rst_grant", 64'(s_ar_ready), 64'(2'b01));
        M_RD_ADDR_VALID = '0;
        cycle();
        cycle();

        check("sb_drain", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
